// File: rtl/axis_packet_pkg.sv
// Shared types for the packet-rebuild block: FSM state encoding and default descriptor width.
// Latency: n/a (types only).
// Backpressure: n/a.
package axis_packet_pkg;

    localparam int LEN_W_DEFAULT = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/axis_rebuild_oreg.sv
// Single output register slice for the rebuilt stream (data + regenerated last).
// Latency: 1 cycle from load to out_tvalid.
// Backpressure: holds data/last stable while out_tvalid && !out_tready; caller only loads when free.
module axis_rebuild_oreg #(
    parameter int DSIZE = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             load,
    input  logic [DSIZE-1:0] load_dat,
    input  logic             load_last,
    input  logic             out_tready,
    output logic             out_tvalid,
    output logic [DSIZE-1:0] out_tdata,
    output logic             out_tlast
);

    logic             vld_q, vld_d;
    logic [DSIZE-1:0] dat_q, dat_d;
    logic             last_q, last_d;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        last_d = last_q;
        if (load) begin
            vld_d  = 1'b1;
            dat_d  = load_dat;
            last_d = load_last;
        end else if (out_tready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            last_q <= last_d;
        end
    end

    assign out_tvalid = vld_q;
    assign out_tdata  = dat_q;
    assign out_tlast  = last_q;

endmodule

// File: rtl/axi_stream_packet_rebuild.sv
// Rebuilds AXI-Stream packets, regenerating tlast from a beats-1 length descriptor stream.
// Latency: 1 cycle in-beat to out_tvalid; back-to-back packets with no bubble.
// Backpressure: in_tready follows the output slot; optional tlast checker under AXIS_PACKET_REBUILD_TLAST_CHECK_EN.
module axi_stream_packet_rebuild
    import axis_packet_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [LEN_W-1:0] len_tdata,
    input  logic             len_tvalid,
    output logic             len_tready,
    input  logic [DSIZE-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic             in_tlast,
    output logic [DSIZE-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             out_tlast,
    output logic             err_mismatch,
    output logic [7:0]       err_cnt
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             cnt_zero;
    logic             slot_free;
    logic             in_fire;
    logic             len_fire;

    assign cnt_zero  = (cnt_q == '0);
    assign slot_free = !out_tvalid || out_tready;
    assign in_fire   = in_tvalid && in_tready;
    assign len_fire  = len_tvalid && len_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (len_fire) begin
                    cnt_d   = len_tdata;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (in_fire) begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else if (len_fire) begin
                        cnt_d = len_tdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // Descriptor is taken on the last beat itself so consecutive packets stream without a gap.
    always_comb begin
        len_tready = 1'b0;
        in_tready  = 1'b0;
        if (aresetn) begin
            case (state_q)
                IDLE:   len_tready = 1'b1;
                STREAM: begin
                    in_tready  = slot_free;
                    len_tready = in_tvalid && slot_free && cnt_zero;
                end
            endcase
        end
    end

    axis_rebuild_oreg #(
        .DSIZE (DSIZE)
    ) u_oreg (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .load       (in_fire),
        .load_dat   (in_tdata),
        .load_last  (cnt_zero),
        .out_tready (out_tready),
        .out_tvalid (out_tvalid),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast)
    );

`ifdef AXIS_PACKET_REBUILD_TLAST_CHECK_EN
    logic       mismatch;
    logic       err_mismatch_q, err_mismatch_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign mismatch = in_fire && (in_tlast != cnt_zero);

    always_comb begin
        err_mismatch_d = err_mismatch_q | mismatch;
        err_cnt_d      = err_cnt_q;
        if (mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            err_mismatch_q <= 1'b0;
            err_cnt_q      <= 8'd0;
        end else begin
            err_mismatch_q <= err_mismatch_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign err_mismatch = err_mismatch_q;
    assign err_cnt      = err_cnt_q;
`else
    logic unused_tlast;
    assign unused_tlast = in_tlast;
    assign err_mismatch = 1'b0;
    assign err_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_axi_stream_packet_rebuild.sv
// Bench for axi_stream_packet_rebuild: directed scenarios plus randomized traffic against a packet-level model.
// Expected beats are derived from descriptor lengths; tlast checker outputs follow AXIS_PACKET_REBUILD_TLAST_CHECK_EN.
module tb_axi_stream_packet_rebuild;

    localparam int DSIZE = 32;
    localparam int LEN_W = 8;

    typedef struct packed {
        logic [DSIZE-1:0] d;
        logic             l;
    } beat_t;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [LEN_W-1:0] len_tdata;
    logic             len_tvalid;
    logic             len_tready;
    logic [DSIZE-1:0] in_tdata;
    logic             in_tvalid;
    logic             in_tready;
    logic             in_tlast;
    logic [DSIZE-1:0] out_tdata;
    logic             out_tvalid;
    logic             out_tready;
    logic             out_tlast;
    logic             err_mismatch;
    logic [7:0]       err_cnt;

    always #5 aclk = ~aclk;

    axi_stream_packet_rebuild #(
        .DSIZE (DSIZE),
        .LEN_W (LEN_W)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .len_tdata    (len_tdata),
        .len_tvalid   (len_tvalid),
        .len_tready   (len_tready),
        .in_tdata     (in_tdata),
        .in_tvalid    (in_tvalid),
        .in_tready    (in_tready),
        .in_tlast     (in_tlast),
        .out_tdata    (out_tdata),
        .out_tvalid   (out_tvalid),
        .out_tready   (out_tready),
        .out_tlast    (out_tlast),
        .err_mismatch (err_mismatch),
        .err_cnt      (err_cnt)
    );

    int    checks = 0;
    int    passed = 0;
    int    fails  = 0;
    int    cyc    = 0;
    int    mis_model = 0;
    int    desc_q[$];
    beat_t pay_q[$];
    beat_t exp_q[$];
    int    fire_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One packet of len+1 beats; the beat at index flip carries a wrong upstream tlast.
    task automatic add_pkt(input int len, input logic [DSIZE-1:0] base, input bit rnd, input int flip);
        desc_q.push_back(len);
        for (int i = 0; i <= len; i++) begin
            beat_t b;
            b.d = rnd ? DSIZE'($urandom) : base + DSIZE'(i);
            b.l = (i == len);
            exp_q.push_back(b);
            if (i == flip) begin
                b.l = !b.l;
                mis_model++;
            end
            pay_q.push_back(b);
        end
    endtask

    task automatic run(input int p_len, input int p_in, input int p_rdy, input bit tog, input int budget);
        bit               stall_p = 1'b0;
        bit               fire_p  = 1'b0;
        logic [DSIZE-1:0] sd = '0;
        logic [DSIZE-1:0] fd = '0;
        logic             sl = 1'b0;
        int               left = budget;
        bit               inf, lf, of;
        beat_t            e;
        fire_cyc.delete();
        out_tready = !tog;
        while (exp_q.size() > 0 && left > 0) begin
            len_tvalid = desc_q.size() > 0 && ($urandom_range(99) < p_len);
            len_tdata  = desc_q.size() > 0 ? LEN_W'(desc_q[0]) : '0;
            in_tvalid  = pay_q.size() > 0 && ($urandom_range(99) < p_in);
            in_tdata   = pay_q.size() > 0 ? pay_q[0].d : '0;
            in_tlast   = pay_q.size() > 0 ? pay_q[0].l : 1'b0;
            out_tready = tog ? !out_tready : ($urandom_range(99) < p_rdy);
            #1;
            if (stall_p) begin
                check("stall_dat", out_tdata, sd);
                check("stall_last", out_tlast, sl);
            end
            if (fire_p) begin
                check("lat_vld", out_tvalid, 1);
                check("lat_dat", out_tdata, fd);
            end
            inf = in_tvalid && in_tready;
            lf  = len_tvalid && len_tready;
            of  = out_tvalid && out_tready;
            if (of) begin
                e = exp_q.pop_front();
                check("out_dat", out_tdata, e.d);
                check("out_last", out_tlast, e.l);
            end
            stall_p = out_tvalid && !out_tready;
            sd      = out_tdata;
            sl      = out_tlast;
            fire_p  = inf;
            fd      = in_tdata;
            if (inf) begin
                pay_q.delete(0);
                fire_cyc.push_back(cyc);
            end
            if (lf) desc_q.delete(0);
            cyc++;
            left--;
            @(negedge aclk);
        end
        check("all_out", exp_q.size(), 0);
        exp_q.delete();
        desc_q.delete();
        len_tvalid = 1'b0;
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        #1;
        check("no_extra", out_tvalid, 0);
`ifdef AXIS_PACKET_REBUILD_TLAST_CHECK_EN
        check("err_cnt", err_cnt, mis_model > 255 ? 255 : mis_model);
        check("err_flag", err_mismatch, mis_model > 0);
`else
        check("err_cnt", err_cnt, 0);
        check("err_flag", err_mismatch, 0);
`endif
        @(negedge aclk);
    endtask

    initial begin
        aresetn    = 1'b0;
        len_tdata  = '0;
        len_tvalid = 1'b0;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_out_vld", out_tvalid, 0);
        check("rst_out_last", out_tlast, 0);
        check("rst_out_dat", out_tdata, 0);
        check("rst_len_rdy", len_tready, 0);
        check("rst_in_rdy", in_tready, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_flag", err_mismatch, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check("idle_len_rdy", len_tready, 1);
        check("idle_in_rdy", in_tready, 0);
        @(negedge aclk);

        // 4-beat packet at full rate
        add_pkt(3, 32'hA0, 1'b0, -1);
        run(100, 100, 100, 1'b0, 100);

        // 1, 1, 3-beat packets back to back: five accepts in five consecutive cycles
        add_pkt(0, 32'h10, 1'b0, -1);
        add_pkt(0, 32'h20, 1'b0, -1);
        add_pkt(2, 32'h30, 1'b0, -1);
        run(100, 100, 100, 1'b0, 100);
        check("b2b_beats", fire_cyc.size(), 5);
        if (fire_cyc.size() == 5) check("b2b_span", fire_cyc[4] - fire_cyc[0], 4);

        // 8-beat packet with out_tready toggling
        add_pkt(7, 32'h70, 1'b0, -1);
        run(100, 100, 0, 1'b1, 200);

        // in-beats offered with no descriptor are held off
        in_tvalid = 1'b1;
        in_tdata  = 32'h50;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("holdoff_rdy", in_tready, 0);
            @(negedge aclk);
        end
        add_pkt(1, 32'h50, 1'b0, -1);
        pay_q.push_back('{d: 32'h99, l: 1'b0});
        run(100, 100, 100, 1'b0, 100);
        in_tvalid = 1'b1;
        in_tdata  = 32'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("post_hold_rdy", in_tready, 0);
            check("post_hold_vld", out_tvalid, 0);
            @(negedge aclk);
        end
        in_tvalid = 1'b0;
        pay_q.delete();

        // tlast disagreements: one in the first packet, one more in the second
        add_pkt(2, 32'hC0, 1'b0, 1);
        run(100, 100, 100, 1'b0, 100);
        add_pkt(2, 32'hD0, 1'b0, 2);
        run(100, 100, 100, 1'b0, 100);

        // reset mid-packet after 2 of 5 beats
        len_tvalid = 1'b1;
        len_tdata  = 8'd4;
        out_tready = 1'b1;
        @(negedge aclk);
        len_tvalid = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = 32'hB0;
        @(negedge aclk);
        in_tdata   = 32'hB1;
        @(negedge aclk);
        in_tvalid  = 1'b0;
        aresetn    = 1'b0;
        #1;
        check("rst_gate_len", len_tready, 0);
        check("rst_gate_in", in_tready, 0);
        @(negedge aclk);
        #1;
        check("midrst_vld", out_tvalid, 0);
        aresetn   = 1'b1;
        mis_model = 0;
        @(negedge aclk);
        add_pkt(0, 32'hE0, 1'b0, -1);
        run(100, 100, 100, 1'b0, 100);

        // all-ones descriptor: 2^LEN_W beats with stalls
        add_pkt((1 << LEN_W) - 1, '0, 1'b1, -1);
        run(100, 85, 75, 1'b0, 3000);

        // randomized traffic
        for (int k = 0; k < 8; k++) begin
            add_pkt($urandom_range(9), '0, 1'b1, -1);
        end
        run(70, 70, 70, 1'b0, 2000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_stream_packet_rebuild.md
AXI_STREAM_PACKET_REBUILD -- requirements
Module: axi_stream_packet_rebuild

Purpose: consumer side of a packet-length queue. Takes a length-descriptor stream plus a data stream with no trusted tlast, and emits AXI-Stream packets with tlast regenerated from the descriptor.

Interface
REQ-001 The module SHALL have these parameters:
- DSIZE, default 32: data width in bits.
- LEN_W, default 16: descriptor width in bits.

REQ-002 The module SHALL have these ports, clock and reset first:
- aclk, input, 1: single clock for all logic.
- aresetn, input, 1: reset; synchronous to aclk and active-low.
- len_tdata, input, LEN_W: packet length as beats-1 (0 means a 1-beat packet).
- len_tvalid, input, 1: descriptor valid.
- len_tready, output, 1: descriptor accepted.
- in_tdata, input, DSIZE: payload beat.
- in_tvalid, input, 1: payload valid.
- in_tready, output, 1: payload accepted.
- in_tlast, input, 1: upstream last flag; used only by the checker.
- out_tdata, output, DSIZE: rebuilt payload.
- out_tvalid, output, 1: output valid.
- out_tready, input, 1: downstream ready.
- out_tlast, output, 1: regenerated last flag.
- err_mismatch, output, 1: sticky flag for a tlast disagreement.
- err_cnt, output, 8: saturating count of tlast disagreements.

Function
REQ-003 An input handshake SHALL be valid&&ready on the same edge; the len, in and out channels each follow this rule.
REQ-004 The state machine SHALL have two states, IDLE and STREAM, and a LEN_W-bit down-counter cnt.
REQ-005 In IDLE:
- len_tready=1 and in_tready=0.
- A descriptor accept loads cnt=len_tdata and moves the state to STREAM.
REQ-006 In STREAM:
- in_tready = !out_tvalid || out_tready.
- Each accepted in-beat with cnt!=0 decrements cnt.
REQ-007 The last beat of a packet is an accepted in-beat with cnt==0.
- On the last beat, len_tready SHALL be 1 in the same cycle, so back-to-back packets have no bubble.
- If a descriptor is also accepted on that edge, cnt reloads and the state stays STREAM.
- Otherwise the state moves to IDLE.
REQ-008 Output register behaviour:
- On an in-beat accept, out_tdata<=in_tdata, out_tlast<=(cnt==0) and out_tvalid<=1.
- Otherwise, if out_tready is high, out_tvalid<=0.
- Latency from input accept to out_tvalid SHALL be exactly 1 cycle.
REQ-009 Ordering and stability:
- Payload order and data SHALL be preserved unmodified.
- out_tdata and out_tlast SHALL stay stable while out_tvalid=1 and out_tready=0.
REQ-010 Full throughput SHALL be 1 beat per cycle while out_tready=1 and both inputs are valid.
REQ-011 A len_tdata of all-ones (2^LEN_W beats) SHALL be handled exactly, with no wrap before the last beat.
REQ-012 In-beats presented while in IDLE SHALL be held off (in_tready=0) and never dropped.

Reset
REQ-013 While aresetn=0 at a rising edge of aclk, the design SHALL load:
- state=IDLE and cnt=0.
- out_tvalid=0, out_tlast=0, out_tdata=0.
- err_mismatch=0 and err_cnt=0.
REQ-014 len_tready and in_tready SHALL be 0 while aresetn=0.
REQ-015 A reset mid-packet SHALL discard the partial packet and any pending output beat; the first descriptor after reset starts a new packet.

Configuration
REQ-016 When AXIS_PACKET_REBUILD_TLAST_CHECK_EN is defined, the checker SHALL be compiled in:
- On each accepted in-beat, in_tlast is compared with (cnt==0).
- On a mismatch, err_mismatch is set and stays set until reset.
- On a mismatch, err_cnt increments and saturates at 255.
- Output data and tlast are unaffected.
REQ-017 When the macro is undefined:
- in_tlast SHALL be ignored.
- err_mismatch and err_cnt SHALL be tied to 0.
- No checker logic SHALL be present.

Structure
REQ-018 The shared package axis_packet_pkg SHALL hold the state enum (IDLE, STREAM) and the default LEN_W constant.
REQ-019 The output register stage SHALL be a separate sub-module, axis_rebuild_oreg; the counter and state machine live in the top module.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Descriptor 3, then 4 in-beats 0xA0..0xA3, out_tready=1 -> outputs 0xA0..0xA3 with tlast only on 0xA3, each 1 cycle after its input.
- Descriptors 0, 0, 2 back-to-back with continuous in-beats -> 1-beat, 1-beat, 3-beat packets, no idle cycle between them, tlast on beats 1, 2 and 5.
- Descriptor 7 with out_tready toggling 1010... -> no beat lost or duplicated, out_tdata and out_tlast held while stalled, tlast on beat 8.
- in_tvalid=1 with no descriptor for 20 cycles -> in_tready=0 throughout; descriptor 1 then releases exactly 2 beats.
- Reset asserted after 2 of 5 beats -> out_tvalid=0 next cycle; a fresh descriptor 0 then yields a single beat with tlast=1.
- With the macro defined: descriptor 2 and in_tlast=1 on beat 2 -> err_mismatch=1, err_cnt=1 (err_cnt reaches 2 if in_tlast=0 on beat 3); with the macro undefined both outputs stay 0.
